// File: rtl/uart_tx_if.sv
// Device-bridge register port shared by the UART transmitter and its bus master.
// Word-address, write-enable, write-data and combinational read-data, same shape as the timer.
interface uart_tx_if;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] WD;
    logic [31:0] RD;

    modport master (output we, output addr, output WD, input RD);
    modport slave  (input we, input addr, input WD, output RD);
endinterface

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: 4-entry byte FIFO, programmable bit period,
// level interrupt when the transmitter has fully drained.
module uart_tx #(
    parameter int unsigned DEPTH   = 4,
    parameter logic [15:0] DIV_RST = 16'd16
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus,
    output logic       IRQ,
    output logic       txd
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // FIFO storage and pointers
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Register file
    logic          im_q;
    logic          ovf_q;
    logic [15:0]   div_q;
    logic [7:0]    last_q;

    // Transmit engine
    state_e        state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_q;
    logic [15:0]   per_q;
    logic [15:0]   shadow_q;
    logic          txd_q;
    logic          irq_q;

    logic          empty;
    logic          full;
    logic          busy;
    logic          per_done;
    logic          pop;
    logic          push;
    logic          wr_data;
    logic          wr_ctrl;
    logic          wr_div;
    logic [15:0]   div_eff;
    logic [2:0]    cnt_field;
    logic [31:0]   rd_data;
    logic          unused_wd;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign busy      = (state_q != S_IDLE);
    assign per_done  = (per_q == 16'd0);
    assign div_eff   = (div_q == 16'd0) ? 16'd1 : div_q;
    assign cnt_field = 3'(count_q);

    assign wr_data = bus.we && (bus.addr == 2'd0);
    assign wr_ctrl = bus.we && (bus.addr == 2'd1);
    assign wr_div  = bus.we && (bus.addr == 2'd2);

    // The engine takes a byte when idle, or straight out of a finished stop bit
    assign pop  = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && per_done));
    // A full FIFO still accepts a write in the cycle a pop frees a slot
    assign push = wr_data && (!full || pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.WD[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_q   <= 1'b0;
            ovf_q  <= 1'b0;
            div_q  <= DIV_RST;
            last_q <= 8'd0;
        end else begin
            if (wr_data) begin
                last_q <= bus.WD[7:0];
                if (!push) begin
                    ovf_q <= 1'b1;
                end
            end
            if (wr_ctrl) begin
                im_q  <= bus.WD[0];
                ovf_q <= 1'b0;
            end
            if (wr_div) begin
                div_q <= bus.WD[15:0];
            end
        end
    end

    // Bit timing uses shadow_q, latched at each pop, so DIV writes only affect later frames
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shift_q  <= 8'd0;
            bit_q    <= 3'd0;
            per_q    <= 16'd0;
            shadow_q <= 16'd1;
            txd_q    <= 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shift_q  <= mem_q[rd_ptr_q];
                        shadow_q <= div_eff;
                        per_q    <= div_eff - 16'd1;
                        txd_q    <= 1'b0;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (per_done) begin
                        bit_q   <= 3'd0;
                        per_q   <= shadow_q - 16'd1;
                        txd_q   <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        per_q <= per_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (per_done) begin
                        per_q <= shadow_q - 16'd1;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        per_q <= per_q - 16'd1;
                    end
                end
                S_STOP: begin
                    if (per_done) begin
                        if (pop) begin
                            shift_q  <= mem_q[rd_ptr_q];
                            shadow_q <= div_eff;
                            per_q    <= div_eff - 16'd1;
                            txd_q    <= 1'b0;
                            state_q  <= S_START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        per_q <= per_q - 16'd1;
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= im_q && empty && !busy;
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (bus.addr)
            2'd0:    rd_data = {24'd0, last_q};
            2'd1:    rd_data = {31'd0, im_q};
            2'd2:    rd_data = {16'd0, div_q};
            default: rd_data = {25'd0, ovf_q, empty, full, busy, cnt_field};
        endcase
    end

    assign bus.RD    = rd_data;
    assign txd       = txd_q;
    assign IRQ       = irq_q;
    assign unused_wd = ^bus.WD[31:16];
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a txd frame monitor pops expected bytes/bit periods from a
// scoreboard queue filled as DATA writes are issued; register and timing points checked inline.
module tb_uart_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;
    logic txd;

    uart_tx_if bus ();

    uart_tx #(
        .DEPTH   (4),
        .DIV_RST (16'd16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .IRQ (irq),
        .txd (txd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         p;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   frames_seen  = 0;
    bit   mon_active   = 1'b0;
    bit   mon_skip     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we   = 1'b1;
        bus.addr = a;
        bus.WD   = d;
        @(posedge clk);
        #1;
        bus.we   = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.RD;
    endtask

    task automatic push_exp(input logic [7:0] b, input int p);
        exp_t e;
        e.b = b;
        e.p = p;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || mon_active) && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_pending", sb_q.size(), 0);
    endtask

    // Frame monitor: samples txd on the falling edge, one sample per clock
    logic [9:0] mon_frame;
    logic [7:0] mon_rx;
    logic [7:0] mon_exp_b;
    int         mon_p;
    int         mon_cnt;
    int         mon_err;

    initial begin
        exp_t e;
        int   idx;
        int   bi;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
                mon_skip   = 1'b0;
            end else if (!mon_active) begin
                if (mon_skip) begin
                    if (txd === 1'b1) mon_skip = 1'b0;
                end else if (txd === 1'b0) begin
                    if (sb_q.size() == 0) begin
                        check("spurious_frame", {31'd0, txd}, 32'd1);
                        mon_skip = 1'b1;
                    end else begin
                        e          = sb_q.pop_front();
                        mon_exp_b  = e.b;
                        mon_p      = e.p;
                        mon_frame  = {1'b1, e.b, 1'b0};
                        mon_rx     = 8'd0;
                        mon_cnt    = 1;
                        mon_err    = 0;
                        mon_active = 1'b1;
                    end
                end
            end else begin
                idx = mon_cnt;
                bi  = idx / mon_p;
                if (txd !== mon_frame[bi]) mon_err++;
                if ((bi >= 1) && (bi <= 8) && ((idx % mon_p) == (mon_p / 2)))
                    mon_rx[bi-1] = txd;
                mon_cnt++;
                if (mon_cnt == 10 * mon_p) begin
                    check("frame_shape_errors", mon_err, 0);
                    check("frame_rx_byte", {24'd0, mon_rx}, {24'd0, mon_exp_b});
                    frames_seen++;
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests_run);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          f0;

        bus.we   = 1'b0;
        bus.addr = 2'd0;
        bus.WD   = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_txd", {31'd0, txd}, 32'd1);
        check("reset_irq", {31'd0, irq}, 32'd0);
        bus_read(2'd3, rd); check("reset_status", rd, 32'h20);
        bus_read(2'd2, rd); check("reset_div", rd, 32'd16);
        bus_read(2'd1, rd); check("reset_ctrl", rd, 32'd0);
        bus_read(2'd0, rd); check("reset_data", rd, 32'd0);

        // Single byte, DIV=4
        f0 = frames_seen;
        bus_write(2'd2, 32'd4);
        bus_write(2'd1, 32'd1);
        push_exp(8'hA5, 4);
        bus_write(2'd0, 32'hA5);
        check("single_txd_at_write", {31'd0, txd}, 32'd1);
        bus_read(2'd3, rd); check("single_status_queued", rd, 32'h01);
        bus_read(2'd0, rd); check("single_data_readback", rd, 32'hA5);
        @(posedge clk); #1;
        check("single_start_latency", {31'd0, txd}, 32'd0);
        check("single_irq_busy", {31'd0, irq}, 32'd0);
        repeat (39) @(posedge clk); #1;
        check("single_stop_bit", {31'd0, txd}, 32'd1);
        check("single_irq_in_stop", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        check("single_irq_frame_end", {31'd0, irq}, 32'd0);
        bus_read(2'd3, rd); check("single_status_idle", rd, 32'h20);
        @(posedge clk); #1;
        check("single_irq_rise", {31'd0, irq}, 32'd1);
        wait_drain(100);
        check("single_frames", frames_seen - f0, 1);

        // Back-to-back, DIV=2
        f0 = frames_seen;
        bus_write(2'd2, 32'd2);
        push_exp(8'h00, 2); bus_write(2'd0, 32'h00);
        push_exp(8'hFF, 2); bus_write(2'd0, 32'hFF);
        push_exp(8'h55, 2); bus_write(2'd0, 32'h55);
        bus_read(2'd3, rd); check("b2b_status_peak", rd, 32'h0A);
        repeat (58) @(posedge clk); #1;
        bus_read(2'd3, rd); check("b2b_busy_at_60", rd, 32'h28);
        @(posedge clk); #1;
        bus_read(2'd3, rd); check("b2b_idle_after_60", rd, 32'h20);
        wait_drain(100);
        check("b2b_frames", frames_seen - f0, 3);

        // Overflow, DIV=100
        f0 = frames_seen;
        bus_write(2'd2, 32'd100);
        push_exp(8'h11, 100); bus_write(2'd0, 32'h11);
        push_exp(8'h22, 100); bus_write(2'd0, 32'h22);
        push_exp(8'h33, 100); bus_write(2'd0, 32'h33);
        push_exp(8'h44, 100); bus_write(2'd0, 32'h44);
        push_exp(8'h55, 100); bus_write(2'd0, 32'h55);
        bus_write(2'd0, 32'h66);
        bus_read(2'd3, rd); check("ovf_status", rd, 32'h5C);
        bus_write(2'd1, 32'd1);
        bus_read(2'd3, rd); check("ovf_cleared", rd, 32'h1C);
        wait_drain(6000);
        repeat (300) @(posedge clk); #1;
        check("ovf_frames", frames_seen - f0, 5);
        bus_read(2'd3, rd); check("ovf_status_end", rd, 32'h20);

        // DIV change while a frame is in flight
        f0 = frames_seen;
        bus_write(2'd2, 32'd3);
        push_exp(8'h3C, 3); bus_write(2'd0, 32'h3C);
        push_exp(8'hC3, 5); bus_write(2'd0, 32'hC3);
        repeat (10) @(posedge clk);
        bus_write(2'd2, 32'd5);
        bus_read(2'd2, rd); check("divchg_readback", rd, 32'd5);
        wait_drain(200);
        check("divchg_frames", frames_seen - f0, 2);

        // DIV=0 behaves as one-cycle bits
        f0 = frames_seen;
        bus_write(2'd2, 32'd0);
        bus_read(2'd2, rd); check("div0_readback", rd, 32'd0);
        push_exp(8'h96, 1); bus_write(2'd0, 32'h96);
        @(posedge clk); #1;
        check("div0_start", {31'd0, txd}, 32'd0);
        repeat (9) @(posedge clk); #1;
        bus_read(2'd3, rd); check("div0_busy_last", rd, 32'h28);
        @(posedge clk); #1;
        bus_read(2'd3, rd); check("div0_idle", rd, 32'h20);
        wait_drain(50);
        check("div0_frames", frames_seen - f0, 1);

        // Reset during data bit 4, with a second byte queued and a write colliding with reset
        bus_write(2'd2, 32'd4);
        push_exp(8'h0F, 4); bus_write(2'd0, 32'h0F);
        push_exp(8'hF0, 4); bus_write(2'd0, 32'hF0);
        repeat (21) @(posedge clk); #1;
        rst = 1'b1;
        sb_q.delete();
        f0 = frames_seen;
        @(posedge clk); #1;
        check("rstmid_txd", {31'd0, txd}, 32'd1);
        check("rstmid_irq", {31'd0, irq}, 32'd0);
        bus_read(2'd3, rd); check("rstmid_status", rd, 32'h20);
        bus_write(2'd0, 32'h77);
        rst = 1'b0;
        bus_read(2'd3, rd); check("rst_priority_status", rd, 32'h20);
        bus_read(2'd0, rd); check("rst_priority_data", rd, 32'd0);
        bus_read(2'd2, rd); check("rstmid_div", rd, 32'd16);
        repeat (200) @(posedge clk); #1;
        check("rstmid_no_frames", frames_seen - f0, 0);
        check("rstmid_txd_idle", {31'd0, txd}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Memory-mapped UART transmitter peripheral on the CPU's device bridge, the outbound serial counterpart to the switch input device. The CPU writes bytes into a 4-entry FIFO through the bridge's device write port; the block serialises them as 8N1 frames on `txd` at a programmable bit period. It raises a level interrupt on the bridge's hardware-interrupt path when the transmitter has drained. Register access uses the same word-address/write-enable/write-data/read-data shape as the timer.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries (power of two; count field sized for 4).
- `DIV_RST`, 16'd16, reset value of the bit-period divisor.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `we`  in  1  register write enable from bridge, sampled on the rising edge.
- `addr`  in  2  register select (`PrAddr[3:2]`).
- `WD`  in  32  write data from bridge (`devWD`).
- `RD`  out  32  read data, combinational from `addr` and current state.
- `IRQ`  out  1  interrupt request, level, registered.
- `txd`  out  1  serial output, idle high, registered.

## Operation
- Register map (addr):
  - 0 DATA: write pushes `WD[7:0]` into FIFO; read returns `{24'b0, last byte written}`.
  - 1 CTRL: bit0 IM (interrupt mask, 1 = enabled); any write also clears OVF. Read `{31'b0, IM}`.
  - 2 DIV: bits[15:0] bit period in clocks; 0 is treated as 1. Read `{16'b0, DIV}`.
  - 3 STATUS (read-only, writes ignored): [2:0] count, [3] busy, [4] full, [5] empty, [6] OVF, rest 0.
- FIFO: push on DATA write when not full. Write when full is dropped, sets sticky OVF. A push and pop in the same cycle when full is accepted (count unchanged). Pointers wrap modulo DEPTH.
- Transmit FSM: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1. If FIFO non-empty: pop into shift register, latch DIV into the period shadow, go to START.
  - START: `txd`=0 for one period, then DATA with bit index 0.
  - DATA: `txd`=shift[0], LSB first; shift right each period; after 8 periods go to STOP.
  - STOP: `txd`=1 for one period. At period end, if FIFO non-empty, pop and go directly to START (no idle gap); else IDLE.
- Period counter: loads shadow-1 on state/bit entry, counts down, advances at 0. A DIV write mid-frame affects only the next frame.
- busy = state != IDLE.
- IRQ = IM & empty & !busy, registered (asserts the cycle after the condition holds).
- Reset values: `txd`=1, `IRQ`=0, state IDLE, FIFO empty, count 0, IM=0, OVF=0, DIV=DIV_RST, last byte 0. `RD` follows from these.

## Timing
- DATA write accepted at edge E0. FSM pops at E1 and `txd` falls at E1 (latency 1 cycle from write edge).
- Each bit lasts exactly DIV' = max(DIV,1) cycles. One frame = 10·DIV' cycles. Back-to-back frames are contiguous.
- STATUS count reflects a push at the edge after the write. A pop decrements count at the edge that starts the frame.
- Reset mid-frame: at the reset edge `txd` returns to 1, FIFO is flushed, and the pending byte is discarded. No partial frame resumes.
- Reset has priority over `we` in the same cycle.

## Test plan
- Reset: after `rst` is held 2 cycles, `txd`=1, IRQ=0, STATUS reads 0x20, DIV reads 16.
- Single byte: write DIV=4, CTRL=1, then DATA=0xA5.
  - `txd` falls 1 cycle after the DATA write edge.
  - `txd` shows bits 0,1,0,1,0,0,1,0,1 then stop 1, each 4 cycles (40 cycles total).
  - IRQ rises 1 cycle after the frame ends.
- Back-to-back: with DIV=2, write 0x00, 0xFF, 0x55 in consecutive cycles.
  - Frames are contiguous, 20 cycles each.
  - STATUS count peaks at 2.
  - busy drops after 60 cycles.
- Overflow: with DIV=100, write 6 bytes quickly.
  - First pops immediately, next 4 fill FIFO (full=1), 6th sets OVF; STATUS reads 0x5C.
  - A CTRL write clears OVF.
  - Exactly 5 frames are transmitted.
- DIV change mid-frame: start a frame with DIV=3, write DIV=5 during DATA with a second byte queued.
  - The first frame keeps 3-cycle bits; the second uses 5.
  - DIV=0 yields 1-cycle bits.
- Reset mid-frame: assert `rst` during bit 4. `txd`=1 next edge, STATUS reads 0x20, and no further frames follow.
